l_stf_seq: RTL

- Sequencer directly upstream of the legacy short-training-field ROM in the openofdm_tx chain.
- On a start pulse, it walks the ROM address 0..15 for NUM_REP repetitions. By default this yields the 160-sample (8 us at 20 MS/s) L-STF.
- Applies the 802.11 edge window (halving) to the first sample. Registers each sample onto an AXI-stream-style output toward the preamble/IFFT mux.
- Provides busy/done status to the TX controller.

---
 rtl/l_stf_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/l_stf_seq.sv
// l_stf_seq: walks the legacy short-training-field ROM and streams the
// samples toward the preamble/IFFT mux. The field is NUM_REP repetitions of
// 16 ROM entries. The first sample can be edge-windowed (halved).
// A registered AXI-stream style output carries the samples.
// busy/done status is provided for the TX controller.
module l_stf_seq #(
    parameter int NUM_REP = 10,
    parameter bit WIN_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic [3:0]  rom_addr,
    input  logic [31:0] rom_dout,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [7:0] LAST_CNT = 8'(NUM_REP * 16 - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        load;
    logic        handshake;
    logic [31:0] win_sample;

    assign load      = !tvalid_q || m_tready;
    assign handshake = tvalid_q && m_tready;

    // Edge window: arithmetic halving of I and Q, applied only to sample 0
    always_comb begin
        win_sample = rom_dout;
        if (WIN_EN && (cnt_q == 8'd0)) begin
            win_sample = {rom_dout[31], rom_dout[31:17], rom_dout[15], rom_dout[15:1]};
        end
    end

    // Next-state logic for the sequencer FSM, counter and output register
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // a start coinciding with the done pulse is deliberately dropped
                if (start && !done_q) begin
                    state_d = S_RUN;
                    cnt_d   = 8'd0;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (load) begin
                    tdata_d  = win_sample;
                    tvalid_d = 1'b1;
                    tlast_d  = (cnt_q == LAST_CNT);
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_FLUSH;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_FLUSH: begin
                if (handshake) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            tdata_q  <= 32'd0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign rom_addr = cnt_q[3:0];
    assign m_tdata  = tdata_q;
    assign m_tvalid = tvalid_q;
    assign m_tlast  = tlast_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
